// File: rtl/prbs_pkg.sv
// Shared types and elaboration-time helpers for the PRBS checker and generator blocks.
package prbs_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_e;

   // Bits needed to hold values 0..value-1, never less than one so it is usable as a vector width.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) begin
            result++;
         end
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational NBITS-wide PRBS word predictor: history holds the last POLY1 bits, bit 0 newest.
module prbs_predict
   import prbs_pkg::*;
#(
   parameter int NBITS = 2,
   parameter int POLY1 = 7,
   parameter int POLY2 = 6
) (
   input  logic [POLY1-1:0] hist_i,
   output logic [NBITS-1:0] p_o,
   output logic [POLY1-1:0] hist_o
);

   logic [POLY1-1:0] work;
   logic [NBITS-1:0] pred;

   // Bits predicted earlier in the word feed back into the history before the next bit is formed.
   always_comb begin
      work = hist_i;
      pred = '0;
      for (int i = 0; i < NBITS; i++) begin
         pred[i] = work[POLY1-1] ^ work[POLY2-1];
         work    = {work[POLY1-2:0], pred[i]};
      end
   end

   assign p_o    = pred;
   assign hist_o = work;

endmodule

// File: rtl/prbscheck_parallel_lock.sv
// Parallel PRBS checker with SEARCH/VERIFY/LOCKED acquisition, saturating bit-error count
// and a sticky lock-loss flag.
module prbscheck_parallel_lock
   import prbs_pkg::*;
#(
   parameter int NBITS      = 2,
   parameter int POLY1      = 7,
   parameter int POLY2      = 6,
   parameter int LOCK_CNT   = 8,
   parameter int UNLOCK_ERR = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NBITS-1:0]     in,
   input  logic                 in_valid,
   input  logic                 invert,
   input  logic                 clear,
   output logic                 locked,
   output logic                 error,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 lock_lost
);

   localparam int S       = ceil_div(POLY1, NBITS);
   localparam int SEED_W  = clog2(S + 1);
   localparam int MATCH_W = clog2(LOCK_CNT + 1);
   localparam int UERR_W  = clog2(UNLOCK_ERR + 1);
   localparam int PC_W    = clog2(NBITS + 1);
   localparam int SUM_W   = ERR_CNT_W + PC_W + 1;

   if (POLY2 < 1 || POLY2 >= POLY1 || NBITS < 1 || LOCK_CNT < 1 ||
       UNLOCK_ERR < 1 || ERR_CNT_W < 1) begin : g_bad_params
      $error("prbscheck_parallel_lock: illegal parameter combination");
   end

   prbs_state_e          state_q, state_d;
   logic [SEED_W-1:0]    seed_cnt_q, seed_cnt_d;
   logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
   logic [UERR_W-1:0]    cons_err_q, cons_err_d;
   logic [POLY1-1:0]     hist_q, hist_d;
   logic                 locked_q, locked_d;
   logic                 error_q, error_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 lock_lost_q, lock_lost_d;

   logic [NBITS-1:0]     r;
   logic [NBITS-1:0]     p;
   logic [NBITS-1:0]     diff;
   logic                 mismatch;
   logic [POLY1-1:0]     hist_pred;
   logic [POLY1-1:0]     hist_load;
   logic [PC_W-1:0]      err_bits;
   logic [SUM_W-1:0]     err_sum;
   logic                 word_err;
   logic                 unlock_event;

   assign r        = in ^ {NBITS{invert}};
   assign diff     = r ^ p;
   assign mismatch = (diff != '0);

   prbs_predict #(
      .NBITS (NBITS),
      .POLY1 (POLY1),
      .POLY2 (POLY2)
   ) u_predict (
      .hist_i (hist_q),
      .p_o    (p),
      .hist_o (hist_pred)
   );

   always_comb begin
      hist_load = hist_q;
      for (int i = 0; i < NBITS; i++) begin
         hist_load = {hist_load[POLY1-2:0], r[i]};
      end
   end

   always_comb begin
      err_bits = '0;
      for (int i = 0; i < NBITS; i++) begin
         err_bits = err_bits + PC_W'(diff[i]);
      end
   end

   assign word_err     = in_valid && (state_q == LOCKED) && mismatch;
   assign unlock_event = word_err && (cons_err_q == UERR_W'(UNLOCK_ERR - 1));
   assign err_sum      = SUM_W'(err_cnt_q) + SUM_W'(err_bits);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SEARCH;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         cons_err_q  <= '0;
         hist_q      <= '0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         cons_err_q  <= cons_err_d;
         hist_q      <= hist_d;
         locked_q    <= locked_d;
         error_q     <= error_d;
         err_cnt_q   <= err_cnt_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   // A failed verify reseeds from the current word, so that word already counts as one seed word.
   always_comb begin
      state_d     = state_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      cons_err_d  = cons_err_q;
      hist_d      = hist_q;
      if (in_valid) begin
         case (state_q)
            SEARCH: begin
               hist_d = hist_load;
               if (seed_cnt_q >= SEED_W'(S - 1)) begin
                  state_d     = VERIFY;
                  seed_cnt_d  = '0;
                  match_cnt_d = '0;
               end else begin
                  seed_cnt_d = seed_cnt_q + 1'b1;
               end
            end
            VERIFY: begin
               hist_d = hist_load;
               if (!mismatch) begin
                  if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                     state_d     = LOCKED;
                     match_cnt_d = '0;
                     cons_err_d  = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 1'b1;
                  end
               end else begin
                  state_d     = SEARCH;
                  match_cnt_d = '0;
                  seed_cnt_d  = SEED_W'(1);
               end
            end
            LOCKED: begin
               hist_d = hist_pred;
               if (unlock_event) begin
                  state_d    = SEARCH;
                  cons_err_d = '0;
                  seed_cnt_d = '0;
               end else if (mismatch) begin
                  cons_err_d = cons_err_q + 1'b1;
               end else begin
                  cons_err_d = '0;
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   // clear beats a coincident error increment, but the error pulse itself still fires.
   always_comb begin
      locked_d    = (state_d == LOCKED);
      error_d     = word_err;
      err_cnt_d   = err_cnt_q;
      lock_lost_d = lock_lost_q;
      if (clear) begin
         err_cnt_d   = '0;
         lock_lost_d = 1'b0;
      end else begin
         if (word_err) begin
            if (err_sum[SUM_W-1:ERR_CNT_W] != '0) begin
               err_cnt_d = '1;
            end else begin
               err_cnt_d = err_sum[ERR_CNT_W-1:0];
            end
         end
         if (unlock_event) begin
            lock_lost_d = 1'b1;
         end
      end
   end

   assign locked    = locked_q;
   assign error     = error_q;
   assign err_cnt   = err_cnt_q;
   assign lock_lost = lock_lost_q;

endmodule
